// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file writeback arbiter.
//   AW_DEF  : default register-address width
//   DW_DEF  : default data width
//   grant_e : identifies which writeback requester owns the write port
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;

   // Requester identity used for the round-robin "last winner" memory.
   typedef enum logic {
      GNT_A = 1'b0,
      GNT_M = 1'b1
   } grant_e;

endpackage

// File: rtl/wb_hold_slot.sv
// ----------------------------------------------------------------------------
// wb_hold_slot
// One-entry holding buffer for a single writeback requester.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   i_valid  : requester offers a write
//   o_ready  : slot is empty and can accept (depends only on the slot flag)
//   i_rd     : destination register of the offered write
//   i_data   : data of the offered write
//   i_clear  : arbiter has granted this slot; empty it on the next edge
//   o_pend   : slot holds a write waiting for the register-file port
//   o_rd     : held destination register
//   o_data   : held data
// ----------------------------------------------------------------------------
module wb_hold_slot
   import regfile_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [AW-1:0] i_rd,
   input  logic [DW-1:0] i_data,
   input  logic          i_clear,
   output logic          o_pend,
   output logic [AW-1:0] o_rd,
   output logic [DW-1:0] o_data
);

   logic          r_pend;
   logic [AW-1:0] r_rd;
   logic [DW-1:0] r_data;
   logic          w_capture;

   // Ready is purely the inverse of the occupancy flag, so a slot freed by a
   // grant only becomes ready after the clearing edge, never on it.
   assign o_ready   = !r_pend;
   assign w_capture = i_valid && !r_pend;

   assign o_pend = r_pend;
   assign o_rd   = r_rd;
   assign o_data = r_data;

   // Occupancy and payload. A clear can only arrive while the slot is full
   // and a capture only while it is empty, so the two never collide; the
   // clear is still given priority so the intent stays explicit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pend <= 1'b0;
         r_rd   <= '0;
         r_data <= '0;
      end else if (i_clear) begin
         r_pend <= 1'b0;
      end else if (w_capture) begin
         r_pend <= 1'b1;
         r_rd   <= i_rd;
         r_data <= i_data;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges ALU and load writebacks onto a single register-file write port.
// Each requester gets a one-entry holding slot; pending slots are granted one
// per cycle, round-robin on ties, into a registered write port. Pending and
// just-written values are bypassed to two read ports.
// Ports:
//   clk, rst                         : clock and synchronous active-low reset
//   a_valid/a_ready/a_rd/a_data      : ALU writeback requester
//   m_valid/m_ready/m_rd/m_data      : memory/load writeback requester
//   regwrite/rd/writedata            : registered register-file write port
//   rs, rt                           : register-file read addresses to snoop
//   fwd1_hit/fwd1_data               : bypass result for rs
//   fwd2_hit/fwd2_data               : bypass result for rt
//   conflict_cnt                     : saturating count of contended cycles
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_rd,
   input  logic [DW-1:0] a_data,
   input  logic          m_valid,
   output logic          m_ready,
   input  logic [AW-1:0] m_rd,
   input  logic [DW-1:0] m_data,
   output logic          regwrite,
   output logic [AW-1:0] rd,
   output logic [DW-1:0] writedata,
   input  logic [AW-1:0] rs,
   input  logic [AW-1:0] rt,
   output logic          fwd1_hit,
   output logic [DW-1:0] fwd1_data,
   output logic          fwd2_hit,
   output logic [DW-1:0] fwd2_data,
   output logic [7:0]    conflict_cnt
);

   logic          w_pendA;
   logic [AW-1:0] w_rdA;
   logic [DW-1:0] w_dataA;
   logic          w_pendM;
   logic [AW-1:0] w_rdM;
   logic [DW-1:0] w_dataM;

   logic          w_anyPend;
   logic          w_bothPend;
   grant_e        w_grant;
   logic          w_clearA;
   logic          w_clearM;
   logic [AW-1:0] w_selRd;
   logic [DW-1:0] w_selData;
   logic          w_secondIsA;

   logic [AW-1:0] w_addr [2];
   logic          w_hit  [2];
   logic [DW-1:0] w_fwd  [2];

   grant_e        r_lastGrant;
   logic          r_regwrite;
   logic [AW-1:0] r_rd;
   logic [DW-1:0] r_writedata;
   logic [7:0]    r_conflictCnt;

   wb_hold_slot #(.AW(AW), .DW(DW)) u_slotA (
      .clk     (clk),
      .rst     (rst),
      .i_valid (a_valid),
      .o_ready (a_ready),
      .i_rd    (a_rd),
      .i_data  (a_data),
      .i_clear (w_clearA),
      .o_pend  (w_pendA),
      .o_rd    (w_rdA),
      .o_data  (w_dataA)
   );

   wb_hold_slot #(.AW(AW), .DW(DW)) u_slotM (
      .clk     (clk),
      .rst     (rst),
      .i_valid (m_valid),
      .o_ready (m_ready),
      .i_rd    (m_rd),
      .i_data  (m_data),
      .i_clear (w_clearM),
      .o_pend  (w_pendM),
      .o_rd    (w_rdM),
      .o_data  (w_dataM)
   );

   assign w_anyPend  = w_pendA || w_pendM;
   assign w_bothPend = w_pendA && w_pendM;

   // Pick the winner: a lone pending slot always wins; on a tie the slot that
   // did not win last time goes first.
   always_comb begin
      w_grant = GNT_A;
      if (w_bothPend) begin
         w_grant = (r_lastGrant == GNT_A) ? GNT_M : GNT_A;
      end else if (w_pendM) begin
         w_grant = GNT_M;
      end
   end

   assign w_clearA  = w_anyPend && (w_grant == GNT_A);
   assign w_clearM  = w_anyPend && (w_grant == GNT_M);
   assign w_selRd   = (w_grant == GNT_A) ? w_rdA   : w_rdM;
   assign w_selData = (w_grant == GNT_A) ? w_dataA : w_dataM;

   // Registered write port. A grant to register 0 still drains the slot and
   // updates rd/writedata, but never raises regwrite. Idle cycles only drop
   // regwrite so rd/writedata keep their last values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_regwrite  <= 1'b0;
         r_rd        <= '0;
         r_writedata <= '0;
         r_lastGrant <= GNT_M;
      end else if (w_anyPend) begin
         r_regwrite  <= (w_selRd != '0);
         r_rd        <= w_selRd;
         r_writedata <= w_selData;
         r_lastGrant <= w_grant;
      end else begin
         r_regwrite  <= 1'b0;
      end
   end

   // Count every edge on which both requesters are waiting, stopping at 255.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_conflictCnt <= '0;
      end else if (w_bothPend && (r_conflictCnt != 8'hFF)) begin
         r_conflictCnt <= r_conflictCnt + 8'd1;
      end
   end

   // When both slots wait, the one granted second is the one that won last
   // time, and it holds the youngest value for any shared register.
   assign w_secondIsA = (r_lastGrant == GNT_A);

   assign w_addr[0] = rs;
   assign w_addr[1] = rt;

   // Bypass lookup for both read ports. Sources are applied oldest first so
   // each later match overrides: output register, then the slot granted
   // first, then the slot granted second. Register 0 never hits.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_hit[i] = 1'b0;
         w_fwd[i] = '0;
         if (w_addr[i] != '0) begin
            if (r_regwrite && (r_rd == w_addr[i])) begin
               w_hit[i] = 1'b1;
               w_fwd[i] = r_writedata;
            end
            if (w_secondIsA) begin
               if (w_pendM && (w_rdM == w_addr[i])) begin
                  w_hit[i] = 1'b1;
                  w_fwd[i] = w_dataM;
               end
               if (w_pendA && (w_rdA == w_addr[i])) begin
                  w_hit[i] = 1'b1;
                  w_fwd[i] = w_dataA;
               end
            end else begin
               if (w_pendA && (w_rdA == w_addr[i])) begin
                  w_hit[i] = 1'b1;
                  w_fwd[i] = w_dataA;
               end
               if (w_pendM && (w_rdM == w_addr[i])) begin
                  w_hit[i] = 1'b1;
                  w_fwd[i] = w_dataM;
               end
            end
         end
      end
   end

   assign fwd1_hit     = w_hit[0];
   assign fwd1_data    = w_fwd[0];
   assign fwd2_hit     = w_hit[1];
   assign fwd2_data    = w_fwd[1];

   assign regwrite     = r_regwrite;
   assign rd           = r_rd;
   assign writedata    = r_writedata;
   assign conflict_cnt = r_conflictCnt;

endmodule
